// File: rtl/regfile_dump_if.sv
// Bundle for the register-file dump reader: control, read port and byte stream.
// The master side is the dump engine; the slave side is the register file and stream sink.
interface regfile_dump_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          start;
  logic [AW-1:0] first_reg;
  logic [AW-1:0] last_reg;
  logic [AW-1:0] dump_raddr;
  logic [DW-1:0] dump_rdata;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  modport master (
    input  start, first_reg, last_reg, dump_rdata, out_ready,
    output dump_raddr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, first_reg, last_reg, dump_rdata, out_ready,
    input  dump_raddr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/regfile_dump.sv
// Walks a register index range through a spare read port and emits a framed
// byte stream: HDR, {idx, 4 data bytes} per register, TRL, XOR checksum.
module regfile_dump #(
  parameter int         AW  = 5,
  parameter int         DW  = 32,
  parameter logic [7:0] HDR = 8'hA5,
  parameter logic [7:0] TRL = 8'h5A
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_dump_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_IDX,
    S_DATA,
    S_TRL,
    S_CHK
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] cur_reg;
  logic [AW-1:0] last_idx_reg;
  logic          empty_reg;
  logic [DW-1:0] shift_reg;
  logic [7:0]    chk_reg;
  logic [1:0]    cnt_reg;
  logic [AW-1:0] raddr_reg;
  logic [7:0]    out_data_reg;
  logic          out_valid_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          xfer;

  assign xfer           = out_valid_reg && bus.out_ready;
  assign bus.dump_raddr = raddr_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

  function automatic logic [7:0] idx_byte(input logic [AW-1:0] idx);
    logic [7:0] b;
    b         = '0;
    b[AW-1:0] = idx;
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cur_reg       <= '0;
      last_idx_reg  <= '0;
      empty_reg     <= 1'b0;
      shift_reg     <= '0;
      chk_reg       <= '0;
      cnt_reg       <= '0;
      raddr_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            cur_reg       <= bus.first_reg;
            last_idx_reg  <= bus.last_reg;
            empty_reg     <= (bus.first_reg > bus.last_reg);
            chk_reg       <= '0;
            busy_reg      <= 1'b1;
            out_valid_reg <= 1'b1;
            out_data_reg  <= HDR;
            state_reg     <= S_HDR;
          end
        end
        S_HDR: begin
          if (xfer) begin
            if (empty_reg) begin
              out_data_reg <= TRL;
              state_reg    <= S_TRL;
            end else begin
              raddr_reg    <= cur_reg;
              out_data_reg <= idx_byte(cur_reg);
              state_reg    <= S_IDX;
            end
          end
        end
        S_IDX: begin
          // Snapshot the word here; later register writes cannot disturb its bytes.
          // The shifter is kept one byte ahead so out_data stays a plain register.
          if (xfer) begin
            out_data_reg <= bus.dump_rdata[DW-1 -: 8];
            shift_reg    <= bus.dump_rdata << 8;
            chk_reg      <= chk_reg ^ idx_byte(cur_reg);
            cnt_reg      <= '0;
            state_reg    <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            chk_reg <= chk_reg ^ out_data_reg;
            cnt_reg <= cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
              if (cur_reg == last_idx_reg) begin
                out_data_reg <= TRL;
                state_reg    <= S_TRL;
              end else begin
                cur_reg      <= cur_reg + 1'b1;
                raddr_reg    <= cur_reg + 1'b1;
                out_data_reg <= idx_byte(cur_reg + 1'b1);
                state_reg    <= S_IDX;
              end
            end else begin
              out_data_reg <= shift_reg[DW-1 -: 8];
              shift_reg    <= shift_reg << 8;
            end
          end
        end
        S_TRL: begin
          if (xfer) begin
            out_data_reg <= chk_reg;
            state_reg    <= S_CHK;
          end
        end
        S_CHK: begin
          if (xfer) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: expected bytes are queued when a dump is
// started and popped by a monitor as the DUT transfers them.
module tb_regfile_dump;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_dump_if #(.AW(5), .DW(32)) bus ();

  logic [31:0] regs [32];
  assign bus.dump_rdata = regs[bus.dump_raddr];

  regfile_dump #(.AW(5), .DW(32), .HDR(8'hA5), .TRL(8'h5A)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         n_assert  = 0;
  int         n_fail    = 0;
  int         xfer_cnt  = 0;
  int         stall_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  bit         bp_mode    = 1'b0;
  int         bp_i       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sink: out_ready is 1 normally, or the repeating 1,0,0,1 pattern under backpressure.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        bus.out_ready = (bp_i == 0) || (bp_i == 3);
        bp_i = (bp_i + 1) % 4;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // Monitor: one line per transferred byte, plus stall-stability checks.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("byte_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          $display("xfer %0d: byte %02h expected %02h", xfer_cnt, bus.out_data, e);
          check("byte", 32'(bus.out_data), 32'(e));
        end
        xfer_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (prev_stall) stall_cnt++;
    end
  end

  task automatic push_frame(input int f, input int l);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    exp_q.push_back(8'hA5);
    if (f <= l) begin
      for (int i = f; i <= l; i++) begin
        b = 8'(i);
        exp_q.push_back(b);
        c ^= b;
        for (int j = 3; j >= 0; j--) begin
          b = regs[i][8*j +: 8];
          exp_q.push_back(b);
          c ^= b;
        end
      end
    end
    exp_q.push_back(8'h5A);
    exp_q.push_back(c);
  endtask

  task automatic start_dump(input int f, input int l);
    @(posedge clk);
    #1;
    bus.first_reg = 5'(f);
    bus.last_reg  = 5'(l);
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      if (bus.done) found = 1'b1;
    end
    $display("%s: done seen=%0d, bytes left=%0d", tag, found, exp_q.size());
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_single"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
    check({tag, "_valid_clear"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_raddr"}, 32'(bus.dump_raddr), 32'd0);
  endtask

  initial begin
    int  x0;
    bit  hit;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
    regs[3]       = 32'h1234_5678;
    regs[1]       = 32'hDEAD_BEEF;
    bus.start     = 1'b0;
    bus.first_reg = '0;
    bus.last_reg  = '0;

    // Reset and idle, including a reset pulse mid-idle.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("idle");
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_idle("idle_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("idle_after");
    end

    // Single register: A5 03 12 34 56 78 5A 0B.
    push_frame(3, 3);
    check("single_chk_model", 32'(exp_q[7]), 32'h0B);
    start_dump(3, 3);
    check("single_busy", 32'(bus.busy), 32'd1);
    wait_done("single");

    // Backpressure with 1,0,0,1 ready pattern.
    stall_cnt = 0;
    bp_i      = 0;
    bp_mode   = 1'b1;
    push_frame(1, 1);
    start_dump(1, 1);
    wait_done("backpressure");
    bp_mode = 1'b0;
    check("stalls_seen", 32'(stall_cnt > 0), 32'd1);

    // Empty range: A5 5A 00.
    push_frame(5, 2);
    start_dump(5, 2);
    wait_done("empty");

    // Full dump with a write to reg 0x10 after its IDX byte and a start while busy.
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
    push_frame(0, 31);
    x0 = xfer_cnt;
    start_dump(0, 31);
    start_dump(7, 7);
    hit = 1'b0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid && bus.out_ready && bus.dump_raddr == 5'd16 && bus.out_data == 8'h10)
        hit = 1'b1;
    end
    check("snapshot_point", 32'(hit), 32'd1);
    @(posedge clk);
    #1 regs[16] = 32'hCAFE_F00D;
    wait_done("full");
    check("full_bytes", 32'(xfer_cnt - x0), 32'd163);
    regs[16] = 32'h1010_1010;

    // Reset during DATA of reg 2, then a fresh complete frame.
    push_frame(0, 3);
    x0 = xfer_cnt;
    start_dump(0, 3);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(posedge clk);
      #3;
      if (xfer_cnt - x0 >= 13) hit = 1'b1;
    end
    check("reset_point", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("midrst_idle");
    push_frame(0, 3);
    start_dump(0, 3);
    wait_done("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug reader for the CPU register file. On a start pulse it walks a register index range through a dedicated read port.
- It serialises each register into a framed byte stream over a valid/ready interface, intended to feed the board UART transmitter.
- It sits beside the register file on a spare read port and has no effect on CPU execution.

Parameters:
- AW, 5, register index width (32 registers).
- DW, 32, register data width; must be 32, 4 bytes per word.
- HDR, 8'hA5, frame header byte.
- TRL, 8'h5A, frame trailer byte.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a dump.
- first_reg  in  AW  first index to dump; sampled on an accepted start.
- last_reg  in  AW  last index to dump, inclusive; sampled on an accepted start.
- dump_raddr  out  AW  read address to the register-file read port.
- dump_rdata  in  DW  combinational read data for dump_raddr.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - out_valid=0, out_data=0, busy=0, done=0, dump_raddr=0.
  - Index, shift and checksum registers are cleared.
- Reset mid-frame abandons the frame immediately. No partial trailer is sent.
- Frame format: HDR, then for each index i from first_reg to last_reg: {i zero-extended to 8 bits, word[31:24], word[23:16], word[15:8], word[7:0]}, then TRL, then CHK.
  - CHK is the XOR of every index and data byte. HDR and TRL are excluded.
- A byte is transferred on a clock edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data holds stable and out_valid stays 1.
  - out_valid never drops without a transfer.
- FSM states and transitions:
  - IDLE:
    - start=1 → latch first/last, cur=first_reg, chk=0, go to HDR next cycle.
    - If first_reg > last_reg, set an empty flag; the frame is HDR, TRL, CHK=00.
    - busy rises on the cycle after start.
  - HDR: out_data=HDR, out_valid=1. On transfer go to IDX, or to TRL if empty.
  - IDX:
    - out_data = cur, with dump_raddr=cur held since entry to the state.
    - On transfer, capture dump_rdata into the 32-bit shift register, fold cur into chk, set byte count to 0, go to DATA.
  - DATA:
    - out_data = shift[31:24].
    - On transfer, fold the byte into chk, shift left 8, increment byte count.
    - After the 4th byte: if cur==last go to TRL, else cur=cur+1 and go to IDX.
    - cur never wraps, because last ≤ 31 terminates the walk first.
  - TRL: out_data=TRL. On transfer go to CHK.
  - CHK: out_data=chk. On transfer go to IDLE, done=1 for exactly one cycle, busy=0.
- Each register value is the snapshot at its IDX transfer. Later register-file writes do not alter the bytes already being sent for that register.
- start while busy=1 is ignored. start in the same cycle as the CHK transfer is also ignored.
- Minimum frame time with out_ready held at 1: 1 + 5·N + 2 cycles of out_valid, with no bubbles between bytes.
- A full dump of 0..31 is 163 bytes.
- dump_raddr changes only on the cycle entering IDX and is otherwise stable.

Test Plan:
- Reset and idle: rst_n low mid-idle, then release, start never asserted → out_valid, busy and done stay 0; dump_raddr = 0.
- Single-register dump: reg3=0x12345678, first=last=3, out_ready=1 → bytes A5 03 12 34 56 78 5A 0B; done pulses once after the 0B transfer.
- Backpressure: reg1=0xDEADBEEF, first=last=1, out_ready toggles 1,0,0,1,… → out_data stable during every stall; the byte sequence is identical to the unstalled run; no byte is duplicated or dropped.
- Empty range: first=5, last=2 → bytes A5 5A 00; done pulses once.
- Full dump with a snapshot check:
  - Stimulus: registers hold i*0x01010101 for i=0..31, first=0, last=31; a write to reg 0x10 occurs mid-transfer of its data bytes.
  - Required: 163 bytes, correct index order, and reg 0x10 bytes reflect the value at its IDX transfer.
  - A second start issued while busy is ignored.
- Reset mid-frame: rst_n asserted during DATA of reg 2 → out_valid drops the same cycle and busy=0. A fresh start after release produces a complete, correct frame.
